washer_timer: RTL and testbench

WASHER_TIMER -- requirements
Module: washer_timer

---
 rtl/washer_timer.sv | 119 +++++++++++
 tb/tb_washer_timer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/washer_timer.sv
// Washer interval timer: prescaled countdown for fill/wash/drain/rinse/spin
// with pause hold and one sticky done flag per completed interval.
module washer_timer #(
    parameter int PRESCALE = 16,
    parameter int T_FILL   = 20,
    parameter int T_WASH   = 60,
    parameter int T_DRAIN  = 15,
    parameter int T_RINSE  = 40,
    parameter int T_SPIN   = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        R,
    input  logic [2:0]  sel,
    input  logic        pause,
    output logic        Tf,
    output logic        Tw,
    output logic        Td,
    output logic        Tr,
    output logic        Ts,
    output logic        busy,
    output logic        paused,
    output logic [15:0] remaining
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t        state, state_n;
    logic [PW-1:0] pre, pre_n;
    logic [15:0]   rem_n;
    logic [2:0]    selq, selq_n;
    logic [4:0]    flags, flags_n;
    logic          busy_n, paused_n;
    logic          wrap;

    function automatic logic [15:0] tval(input logic [2:0] s);
        case (s)
            3'd0:    return 16'(T_FILL);
            3'd1:    return 16'(T_WASH);
            3'd2:    return 16'(T_DRAIN);
            3'd3:    return 16'(T_RINSE);
            3'd4:    return 16'(T_SPIN);
            default: return 16'd0;
        endcase
    endfunction

    assign wrap = (pre == PW'(PRESCALE - 1));

    always_comb begin
        state_n = state;
        pre_n   = pre;
        rem_n   = remaining;
        selq_n  = selq;
        flags_n = flags;
        if (R) begin
            flags_n = '0;
            pre_n   = '0;
            if (sel <= 3'd4) begin
                rem_n   = tval(sel);
                selq_n  = sel;
                state_n = RUN;
            end else begin
                rem_n   = '0;
                state_n = IDLE;
            end
        end else begin
            case (state)
                RUN, PAUSED: begin
                    if (remaining == 16'd0) begin
                        state_n = DONE;
                        flags_n = 5'b00001 << selq;
                    end else begin
                        state_n = pause ? PAUSED : RUN;
                        // The resume edge counts, so a hold of N edges
                        // delays completion by exactly N edges.
                        if (!pause) begin
                            pre_n = wrap ? '0 : pre + 1'b1;
                            if (wrap) begin
                                rem_n = remaining - 16'd1;
                                if (remaining == 16'd1) begin
                                    state_n = DONE;
                                    flags_n = 5'b00001 << selq;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
        busy_n   = (state_n == RUN) || (state_n == PAUSED);
        paused_n = (state_n == PAUSED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pre       <= '0;
            remaining <= '0;
            selq      <= '0;
            flags     <= '0;
            busy      <= 1'b0;
            paused    <= 1'b0;
        end else begin
            state     <= state_n;
            pre       <= pre_n;
            remaining <= rem_n;
            selq      <= selq_n;
            flags     <= flags_n;
            busy      <= busy_n;
            paused    <= paused_n;
        end
    end

    assign {Ts, Tr, Td, Tw, Tf} = flags;

endmodule

// File: tb/tb_washer_timer.sv
// Bench for washer_timer: vector table per interval select, scoreboard
// of expected done-flag events, and hand sequences for pause/abort/reset.
module tb_washer_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        R = 1'b0;
    logic        pause = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic        Tf, Tw, Td, Tr, Ts, busy, paused;
    logic [15:0] remaining;
    logic [4:0]  fl;

    washer_timer #(
        .PRESCALE(4), .T_FILL(3), .T_WASH(2),
        .T_DRAIN(1), .T_RINSE(0), .T_SPIN(5)
    ) dut (
        .clk(clk), .reset(reset), .R(R), .sel(sel), .pause(pause),
        .Tf(Tf), .Tw(Tw), .Td(Td), .Tr(Tr), .Ts(Ts),
        .busy(busy), .paused(paused), .remaining(remaining)
    );

    assign fl = {Ts, Tr, Td, Tw, Tf};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0] f;
        int         e;
    } exp_t;
    exp_t sb[$];
    exp_t mx;

    typedef struct {
        logic [2:0]  s;
        logic [4:0]  f;
        int          lat;
        logic [15:0] r0;
        logic        v;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic to_edge(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic r_pulse(input logic [2:0] s, output int k);
        @(negedge clk);
        R = 1'b1;
        sel = s;
        @(posedge clk);
        #1;
        R = 1'b0;
        k = cyc;
    endtask

    logic [4:0] prev = 5'd0;
    always @(posedge clk) begin
        #1;
        if (fl != prev && fl != 5'd0) begin
            chk("onehot", 32'($countones(fl)), 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_flag", 32'(fl), 32'd0);
            end else begin
                mx = sb.pop_front();
                chk("sb_flag", 32'(fl), 32'(mx.f));
                chk("sb_edge", cyc, mx.e);
            end
        end
        prev = fl;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k, k2;
        vt[0] = '{3'd0, 5'b00001, 12, 16'd3, 1'b1};
        vt[1] = '{3'd1, 5'b00010, 8,  16'd2, 1'b1};
        vt[2] = '{3'd2, 5'b00100, 4,  16'd1, 1'b1};
        vt[3] = '{3'd3, 5'b01000, 1,  16'd0, 1'b1};
        vt[4] = '{3'd4, 5'b10000, 20, 16'd5, 1'b1};
        vt[5] = '{3'd5, 5'b00000, 0,  16'd0, 1'b0};
        vt[6] = '{3'd6, 5'b00000, 0,  16'd0, 1'b0};
        vt[7] = '{3'd7, 5'b00000, 0,  16'd0, 1'b0};

        @(posedge clk);
        #1;
        chk("rst_flags", 32'(fl), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_paused", 32'(paused), 32'd0);
        chk("rst_rem", 32'(remaining), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            r_pulse(vt[i].s, k);
            if (vt[i].v) sb.push_back('{f: vt[i].f, e: k + vt[i].lat});
            chk("rem_load", 32'(remaining), 32'(vt[i].r0));
            chk("busy_load", 32'(busy), 32'(vt[i].v));
            chk("flags_clr", 32'(fl), 32'd0);
            if (vt[i].v) begin
                to_edge(k + vt[i].lat - 1);
                chk("flag_early", 32'(fl), 32'd0);
                to_edge(k + vt[i].lat);
                chk("flag_done", 32'(fl), 32'(vt[i].f));
                chk("busy_done", 32'(busy), 32'd0);
                chk("rem_done", 32'(remaining), 32'd0);
            end else begin
                to_edge(k + 100);
                chk("inv_flags", 32'(fl), 32'd0);
                chk("inv_busy", 32'(busy), 32'd0);
                chk("inv_rem", 32'(remaining), 32'd0);
            end
        end

        // fill countdown profile
        r_pulse(3'd0, k);
        sb.push_back('{f: 5'b00001, e: k + 12});
        to_edge(k + 3);
        chk("fill_rem3", 32'(remaining), 32'd3);
        to_edge(k + 4);
        chk("fill_rem2", 32'(remaining), 32'd2);
        to_edge(k + 8);
        chk("fill_rem1", 32'(remaining), 32'd1);
        to_edge(k + 12);
        chk("fill_rem0", 32'(remaining), 32'd0);
        chk("fill_busy", 32'(busy), 32'd0);

        // spin with a 10-edge hold
        r_pulse(3'd4, k);
        sb.push_back('{f: 5'b10000, e: k + 30});
        to_edge(k + 6);
        chk("spin_rem_pre", 32'(remaining), 32'd4);
        pause = 1'b1;
        to_edge(k + 8);
        chk("spin_paused", 32'(paused), 32'd1);
        chk("spin_hold_rem", 32'(remaining), 32'd4);
        to_edge(k + 16);
        chk("spin_paused2", 32'(paused), 32'd1);
        chk("spin_hold_rem2", 32'(remaining), 32'd4);
        chk("spin_busy", 32'(busy), 32'd1);
        pause = 1'b0;
        to_edge(k + 17);
        chk("spin_resumed", 32'(paused), 32'd0);
        to_edge(k + 29);
        chk("spin_early", 32'(fl), 32'd0);
        to_edge(k + 30);
        chk("spin_done", 32'(fl), 32'b10000);

        // pause in DONE is ignored
        pause = 1'b1;
        to_edge(k + 33);
        chk("done_pause", 32'(paused), 32'd0);
        chk("done_hold", 32'(fl), 32'b10000);
        pause = 1'b0;

        // zero-length rinse, then drain
        r_pulse(3'd3, k);
        sb.push_back('{f: 5'b01000, e: k + 1});
        to_edge(k + 1);
        chk("rinse_done", 32'(fl), 32'b01000);
        r_pulse(3'd2, k2);
        chk("rinse_clr", 32'(Tr), 32'd0);
        sb.push_back('{f: 5'b00100, e: k2 + 4});
        to_edge(k2 + 4);
        chk("drain_done", 32'(fl), 32'b00100);

        // wash abandoned by a fill restart
        r_pulse(3'd1, k);
        to_edge(k + 4);
        r_pulse(3'd0, k2);
        chk("abort_edge", k2, k + 5);
        sb.push_back('{f: 5'b00001, e: k2 + 12});
        chk("abort_tw", 32'(Tw), 32'd0);
        chk("abort_rem", 32'(remaining), 32'd3);
        to_edge(k2 + 12);
        chk("abort_tf", 32'(fl), 32'b00001);

        // asynchronous reset mid-interval
        r_pulse(3'd0, k);
        to_edge(k + 6);
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rem", 32'(remaining), 32'd0);
        chk("arst_flags", 32'(fl), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        to_edge(k + 40);
        chk("post_rst_flags", 32'(fl), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        r_pulse(3'd1, k2);
        sb.push_back('{f: 5'b00010, e: k2 + 8});
        to_edge(k2 + 8);
        chk("post_rst_tw", 32'(fl), 32'b00010);

        to_edge(cyc + 3);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
